csr_counter_bank: RTL and testbench
===================================

Name: csr_counter_bank

Overview:
- Parametrised machine-mode counter CSR bank, sitting beside the machine CSR file in the write-back stage.
- Implements mcycle/mcycleh, minstret/minstreth, NUM_HPM programmable event counters (mhpmcounterN/hN, mhpmeventN), mcountinhibit, and custom overflow-status/enable CSRs that raise a counter-overflow interrupt.
- CSR writes arrive from WB. Reads are combinational for the decode-stage CSR read mux. Pipeline forwarding is done by the caller.

Parameters:
- CNT_WIDTH, 64, implemented counter width (33..64). Bits above CNT_WIDTH read 0; writes to them are dropped.
- NUM_HPM, 4, number of implemented hpm counters (0..29), mapped to index 3..3+NUM_HPM-1.
- NUM_EVENTS, 8, width of the event input bus (1..32).

Ports:
- clk  in  1  core clock
- cpurst  in  1  synchronous active-high reset
- wr_en  in  1  CSR write strobe from WB
- wr_index  in  12  CSR write address
- wr_wdata  in  32  CSR write data (final value after csrrw/rs/rc op)
- rd_index  in  12  CSR read address
- rd_dat  out  32  CSR read data, combinational
- rd_hit  out  1  rd_index falls in a range owned by this block
- instret_inc  in  1  one instruction retired this cycle
- event_in  in  NUM_EVENTS  per-cycle event pulses
- cnt_ovf_irq  out  1  counter-overflow interrupt request

Behaviour:
- One clock (clk); reset cpurst is synchronous, active-high.
- Reset state (cpurst overrides everything, including mid-operation writes and increments): all counters 0, mhpmevent 0, mcountinhibit 0, mcountovf 0, mcountovf_en 0. cnt_ovf_irq=0 in the cycle after reset.
- Address map:
  - 0xB00/0xB80: mcycle lo/hi.
  - 0xB02/0xB82: minstret lo/hi.
  - 0xB03+i/0xB83+i: hpm i, for i=0..28.
  - 0x323+i: mhpmevent i.
  - 0x320: mcountinhibit.
  - 0x7C0: mcountovf (W1C).
  - 0x7C1: mcountovf_en.
- Counter bit positions (shared by mcountinhibit, mcountovf, mcountovf_en): bit 0 = cycle, bit 2 = instret, bit 3+i = hpm i. Bit 1 and bits for unimplemented counters are hardwired 0.
- rd_hit=1 for every address in the map, including unimplemented hpm indices (these read 0 and ignore writes). rd_hit=0 and rd_dat=0 otherwise.
- hi read = counter[CNT_WIDTH-1:32], zero-extended to 32 bits.
- Increment conditions, each +1 per cycle:
  - mcycle: every cycle unless inhibit[0].
  - minstret: when instret_inc and not inhibit[2].
  - hpm i: when |(event_in & mhpmevent_i[NUM_EVENTS-1:0]) and not inhibit[3+i]. Multiple matching events still give +1.
  - mhpmevent bits at or above NUM_EVENTS read 0.
- Write vs increment:
  - A write to the lo or hi half of a counter loads that half from wr_wdata.
  - The other half holds its value.
  - The increment for that counter is suppressed in the write cycle. Increments resume the next cycle.
- Wrap-around:
  - A counter at all-ones (CNT_WIDTH bits) that increments becomes 0 and sets mcountovf[bit] on the same edge.
  - A write never sets overflow.
- mcountovf W1C: a 1 in wr_wdata clears that bit. If the same bit overflows in the same cycle, set wins.
- cnt_ovf_irq = |(mcountovf & mcountovf_en), driven from registers. It asserts one cycle after the overflow edge.
- Read timing: rd_dat returns register state before the current edge. A same-cycle read of a written or incrementing CSR returns the old value.

Test Plan:
- Reset, then 10 idle cycles: read 0xB00 -> 10 (±0 offset per bench alignment); 0xB02 -> 0; rd_hit(0x123)=0, rd_dat=0.
- Write 0xB00=0xFFFFFFFE, 0xB80=0. Two cycles later read 0xB00=0x00000000 and 0xB80=0x00000001, confirming the carry into hi.
- Write 0x320=0x5, pulse instret_inc 7 cycles: mcycle and minstret frozen. Clear inhibit, then instret_inc 3 cycles: minstret=3.
- mhpmevent0=0x3; event_in=0x3 for 4 cycles, then 0x4 for 4 cycles: mhpmcounter0 (0xB03)=4. Read of 0xB03+NUM_HPM -> 0 with rd_hit=1.
- CNT_WIDTH=40, minstret preloaded to 2^40-1, mcountovf_en=0x4, one retire:
  - minstret=0, mcountovf=0x4, and cnt_ovf_irq=1 one cycle later.
  - W1C 0x4 deasserts the irq next cycle.
  - W1C in the same cycle as a new overflow leaves the bit set.
- Assert cpurst during a write to 0xB80: all CSRs read 0 after reset and cnt_ovf_irq=0.

Source files
------------

// File: rtl/csr_counter_bank.sv
// Machine-mode counter CSR bank: mcycle, minstret, hpm counters/events,
// mcountinhibit and overflow status/enable with a registered overflow interrupt.
module csr_counter_bank #(
  parameter int unsigned CNT_WIDTH  = 64,
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned NUM_EVENTS = 8
) (
  input  logic                  clk,
  input  logic                  cpurst,
  input  logic                  wr_en,
  input  logic [11:0]           wr_index,
  input  logic [31:0]           wr_wdata,
  input  logic [11:0]           rd_index,
  output logic [31:0]           rd_dat,
  output logic                  rd_hit,
  input  logic                  instret_inc,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  cnt_ovf_irq
);

  localparam int unsigned HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
  localparam int unsigned HW    = CNT_WIDTH - 32;
  // Implemented counter bits: cycle, instret and hpm 0..NUM_HPM-1.
  localparam logic [31:0] IMPL  = (NUM_HPM >= 29) ? 32'hFFFF_FFFD :
                                  (((32'd1 << (3 + NUM_HPM)) - 32'd1) & ~32'h2);
  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d, ins_q, ins_d;
  logic [CNT_WIDTH-1:0]  hpm_q [HPM_N];
  logic [CNT_WIDTH-1:0]  hpm_d [HPM_N];
  logic [NUM_EVENTS-1:0] evt_q [HPM_N];
  logic [NUM_EVENTS-1:0] evt_d [HPM_N];
  logic [31:0]           inh_q, inh_d, ovf_q, ovf_d, oen_q, oen_d;
  logic [31:0]           ovf_set, ovf_clr;
  logic                  irq_q;
  logic                  wr_lo, wr_hi, wr_evt, inc;
  logic [4:0]            wk, rk;
  logic [CNT_WIDTH-1:0]  sel;

  function automatic logic [CNT_WIDTH-1:0] cnt_next(
    input logic [CNT_WIDTH-1:0] q,
    input logic                 lo,
    input logic                 hi,
    input logic                 up,
    input logic [31:0]          wd
  );
    cnt_next = q;
    if (lo)      cnt_next[31:0] = wd;
    else if (hi) cnt_next[CNT_WIDTH-1:32] = wd[HW-1:0];
    else if (up) cnt_next = q + ONE;
  endfunction

  assign wk     = wr_index[4:0];
  assign wr_lo  = wr_en && (wr_index[11:5] == 7'h58);
  assign wr_hi  = wr_en && (wr_index[11:5] == 7'h5C);
  assign wr_evt = wr_en && (wr_index[11:5] == 7'h19) && (wk >= 5'd3);

  always_comb begin
    ovf_set = '0;
    inc     = 1'b0;

    cyc_d = cnt_next(cyc_q, wr_lo && wk == 5'd0, wr_hi && wk == 5'd0, !inh_q[0], wr_wdata);
    if (!inh_q[0] && !(wr_lo && wk == 5'd0) && !(wr_hi && wk == 5'd0) && (&cyc_q))
      ovf_set[0] = 1'b1;

    inc   = instret_inc && !inh_q[2];
    ins_d = cnt_next(ins_q, wr_lo && wk == 5'd2, wr_hi && wk == 5'd2, inc, wr_wdata);
    if (inc && !(wr_lo && wk == 5'd2) && !(wr_hi && wk == 5'd2) && (&ins_q))
      ovf_set[2] = 1'b1;

    for (int unsigned i = 0; i < HPM_N; i++) begin
      hpm_d[i] = hpm_q[i];
      evt_d[i] = evt_q[i];
      if (i < NUM_HPM) begin
        inc      = (|(event_in & evt_q[i])) && !inh_q[3+i];
        hpm_d[i] = cnt_next(hpm_q[i], wr_lo && wk == 5'(i+3), wr_hi && wk == 5'(i+3),
                            inc, wr_wdata);
        if (inc && !(wr_lo && wk == 5'(i+3)) && !(wr_hi && wk == 5'(i+3)) && (&hpm_q[i]))
          ovf_set[3+i] = 1'b1;
        if (wr_evt && wk == 5'(i+3))
          evt_d[i] = wr_wdata[NUM_EVENTS-1:0];
      end
    end

    inh_d   = (wr_en && wr_index == 12'h320) ? (wr_wdata & IMPL) : inh_q;
    oen_d   = (wr_en && wr_index == 12'h7C1) ? (wr_wdata & IMPL) : oen_q;
    ovf_clr = (wr_en && wr_index == 12'h7C0) ? wr_wdata : '0;
    // Set is ORed after the clear so a same-cycle overflow survives W1C.
    ovf_d   = ((ovf_q & ~ovf_clr) | ovf_set) & IMPL;
  end

  always_ff @(posedge clk) begin
    if (cpurst) begin
      cyc_q <= '0;
      ins_q <= '0;
      for (int unsigned i = 0; i < HPM_N; i++) begin
        hpm_q[i] <= '0;
        evt_q[i] <= '0;
      end
      inh_q <= '0;
      ovf_q <= '0;
      oen_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
      for (int unsigned i = 0; i < HPM_N; i++) begin
        hpm_q[i] <= hpm_d[i];
        evt_q[i] <= evt_d[i];
      end
      inh_q <= inh_d;
      ovf_q <= ovf_d;
      oen_q <= oen_d;
      irq_q <= |(ovf_q & oen_q);
    end
  end

  assign cnt_ovf_irq = irq_q;
  assign rk          = rd_index[4:0];

  always_comb begin
    sel    = '0;
    rd_dat = '0;
    rd_hit = 1'b0;
    if (rk == 5'd0) sel = cyc_q;
    if (rk == 5'd2) sel = ins_q;
    for (int unsigned i = 0; i < NUM_HPM; i++)
      if (rk == 5'(i+3)) sel = hpm_q[i];

    case (rd_index[11:5])
      7'h58: if (rk != 5'd1) begin
        rd_hit = 1'b1;
        rd_dat = sel[31:0];
      end
      7'h5C: if (rk != 5'd1) begin
        rd_hit = 1'b1;
        rd_dat = 32'(sel[CNT_WIDTH-1:32]);
      end
      7'h19: begin
        if (rk == 5'd0) begin
          rd_hit = 1'b1;
          rd_dat = inh_q;
        end else if (rk >= 5'd3) begin
          rd_hit = 1'b1;
          for (int unsigned i = 0; i < NUM_HPM; i++)
            if (rk == 5'(i+3)) rd_dat = 32'(evt_q[i]);
        end
      end
      7'h3E: begin
        if (rk == 5'd0) begin
          rd_hit = 1'b1;
          rd_dat = ovf_q;
        end else if (rk == 5'd1) begin
          rd_hit = 1'b1;
          rd_dat = oen_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed bench for csr_counter_bank with CNT_WIDTH=40, NUM_HPM=4, NUM_EVENTS=8.
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        cpurst;
  logic        wr_en;
  logic [11:0] wr_index;
  logic [31:0] wr_wdata;
  logic [11:0] rd_index;
  logic [31:0] rd_dat;
  logic        rd_hit;
  logic        instret_inc;
  logic [7:0]  event_in;
  logic        cnt_ovf_irq;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  csr_counter_bank #(.CNT_WIDTH(40), .NUM_HPM(4), .NUM_EVENTS(8)) dut (
    .clk         (clk),
    .cpurst      (cpurst),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_wdata    (wr_wdata),
    .rd_index    (rd_index),
    .rd_dat      (rd_dat),
    .rd_hit      (rd_hit),
    .instret_inc (instret_inc),
    .event_in    (event_in),
    .cnt_ovf_irq (cnt_ovf_irq)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    rd_index = a;
    #1;
    chk(tag, rd_dat, exp);
  endtask

  task automatic hit(input string tag, input logic [11:0] a, input logic exp);
    rd_index = a;
    #1;
    chk(tag, 32'(rd_hit), 32'(exp));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_en    = 1'b1;
    wr_index = a;
    wr_wdata = d;
    tick();
    wr_en    = 1'b0;
  endtask

  initial begin
    cpurst = 1'b1; wr_en = 1'b0; wr_index = '0; wr_wdata = '0;
    rd_index = '0; instret_inc = 1'b0; event_in = '0;
    tick();
    tick();
    cpurst = 1'b0;
    chk("irq_after_reset", 32'(cnt_ovf_irq), 32'h0);
    rd("reset_mcycle", 12'hB00, 32'h0);

    // Free-running cycle counter
    repeat (10) tick();
    rd("mcycle_10", 12'hB00, 32'd10);
    rd("minstret_idle", 12'hB02, 32'h0);
    hit("hit_unmapped", 12'h123, 1'b0);
    chk("dat_unmapped", rd_dat, 32'h0);

    // Carry into the high half; write suppresses same-cycle increment
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    rd("mcycle_lo_held", 12'hB00, 32'hFFFF_FFFE);
    tick();
    tick();
    rd("mcycle_lo_wrap", 12'hB00, 32'h0);
    rd("mcycle_hi_carry", 12'hB80, 32'h1);

    // Inhibit cycle and instret
    wr(12'h320, 32'h5);
    rd("inhibit_rb", 12'h320, 32'h5);
    instret_inc = 1'b1;
    repeat (7) tick();
    instret_inc = 1'b0;
    rd("mcycle_frozen_lo", 12'hB00, 32'h1);
    rd("mcycle_frozen_hi", 12'hB80, 32'h1);
    rd("minstret_frozen", 12'hB02, 32'h0);
    wr(12'h320, 32'h0);
    instret_inc = 1'b1;
    repeat (3) tick();
    instret_inc = 1'b0;
    rd("minstret_3", 12'hB02, 32'd3);
    rd("mcycle_resumed", 12'hB00, 32'd4);

    // HPM event counting
    wr(12'h323, 32'h3);
    event_in = 8'h3;
    repeat (4) tick();
    event_in = 8'h4;
    repeat (4) tick();
    event_in = 8'h0;
    rd("hpm0_lo", 12'hB03, 32'd4);
    rd("hpm0_hi", 12'hB83, 32'd0);
    rd("hpm_unimpl_dat", 12'hB07, 32'h0);
    hit("hpm_unimpl_hit", 12'hB07, 1'b1);
    hit("hit_b01", 12'hB01, 1'b0);
    wr(12'h324, 32'hFFFF_FFFF);
    rd("mhpmevent1_mask", 12'h324, 32'h0000_00FF);

    // Overflow of 40-bit minstret
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'hFFFF_FFFF);
    rd("minstret_hi_mask", 12'hB82, 32'h0000_00FF);
    rd("minstret_lo_pre", 12'hB02, 32'hFFFF_FFFF);
    wr(12'h7C1, 32'h4);
    rd("ovf_en_rb", 12'h7C1, 32'h4);
    rd("ovf_none", 12'h7C0, 32'h0);
    instret_inc = 1'b1;
    tick();
    instret_inc = 1'b0;
    rd("minstret_wrap_lo", 12'hB02, 32'h0);
    rd("minstret_wrap_hi", 12'hB82, 32'h0);
    rd("ovf_set", 12'h7C0, 32'h4);
    chk("irq_not_yet", 32'(cnt_ovf_irq), 32'h0);
    tick();
    chk("irq_asserted", 32'(cnt_ovf_irq), 32'h1);

    wr(12'h7C0, 32'h4);
    rd("ovf_cleared", 12'h7C0, 32'h0);
    chk("irq_still_high", 32'(cnt_ovf_irq), 32'h1);
    tick();
    chk("irq_deasserted", 32'(cnt_ovf_irq), 32'h0);

    // W1C coinciding with a new overflow: set wins
    wr(12'hB02, 32'hFFFF_FFFF);
    wr(12'hB82, 32'h0000_00FF);
    instret_inc = 1'b1;
    wr(12'h7C0, 32'h4);
    instret_inc = 1'b0;
    rd("ovf_set_wins", 12'h7C0, 32'h4);
    rd("minstret_wrap2", 12'hB02, 32'h0);
    tick();
    chk("irq_reassert", 32'(cnt_ovf_irq), 32'h1);

    // Reset overriding a write
    cpurst = 1'b1;
    wr(12'hB80, 32'h12);
    cpurst = 1'b0;
    rd("rst_mcycle_lo", 12'hB00, 32'h0);
    rd("rst_mcycle_hi", 12'hB80, 32'h0);
    rd("rst_minstret", 12'hB02, 32'h0);
    rd("rst_hpm0", 12'hB03, 32'h0);
    rd("rst_evt0", 12'h323, 32'h0);
    rd("rst_inhibit", 12'h320, 32'h0);
    rd("rst_ovf", 12'h7C0, 32'h0);
    rd("rst_ovf_en", 12'h7C1, 32'h0);
    chk("rst_irq", 32'(cnt_ovf_irq), 32'h0);
    tick();
    chk("rst_irq_next", 32'(cnt_ovf_irq), 32'h0);
    rd("rst_mcycle_runs", 12'hB00, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
